// File: rtl/cpu_pkg.sv
// Shared sizes, opcode encodings and register indices for the vector_cpu datapath.
package cpu_pkg;

    localparam int LANES     = 16;
    localparam int LANE_W    = 32;
    localparam int VEC_W     = 512;
    localparam int MEM_DEPTH = 512;
    localparam int ADDR_W    = 9;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_INIT  = 3'b100;

    localparam logic [1:0] REG_A1 = 2'b00;
    localparam logic [1:0] REG_A2 = 2'b01;
    localparam logic [1:0] REG_A3 = 2'b10;
    localparam logic [1:0] REG_A4 = 2'b11;

    // Word address of a lane; the ADDR_W-bit sum wraps modulo MEM_DEPTH by construction.
    function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base, input int lane);
        return base + ADDR_W'(lane);
    endfunction

endpackage

// File: rtl/vector_alu.sv
// Combinational 16-lane add/multiply producing the 64-bit-per-lane pair {A4,A3}.
// CPU_SIGNED_ARITH_EN selects two's-complement lanes; default is unsigned.
module vector_alu
    import cpu_pkg::*;
(
    input  logic [VEC_W-1:0]   a,
    input  logic [VEC_W-1:0]   b,
    input  logic               op_mul,
    output logic [2*VEC_W-1:0] result
);

`ifdef CPU_SIGNED_ARITH_EN
    function automatic logic signed [2*LANE_W-1:0] extend(input logic [LANE_W-1:0] v);
        return {{LANE_W{v[LANE_W-1]}}, v};
    endfunction
`else
    function automatic logic signed [2*LANE_W-1:0] extend(input logic [LANE_W-1:0] v);
        return {{LANE_W{1'b0}}, v};
    endfunction
`endif

    logic signed [2*LANE_W-1:0] ea;
    logic signed [2*LANE_W-1:0] eb;
    logic signed [2*LANE_W-1:0] lane_res;

    // Operands are widened to 64 bits first, so the low 64 bits of sum/product are exact either way.
    always_comb begin
        result   = '0;
        ea       = '0;
        eb       = '0;
        lane_res = '0;
        for (int i = 0; i < LANES; i++) begin
            ea       = extend(a[i*LANE_W +: LANE_W]);
            eb       = extend(b[i*LANE_W +: LANE_W]);
            lane_res = op_mul ? (ea * eb) : (ea + eb);
            result[i*LANE_W +: LANE_W]         = lane_res[LANE_W-1:0];
            result[VEC_W + i*LANE_W +: LANE_W] = lane_res[2*LANE_W-1:LANE_W];
        end
    end

endmodule

// File: rtl/vector_cpu.sv
// SIMD vector datapath: four 512-bit registers, 512x32 data memory, one opcode per clock.
// Build option CPU_SIGNED_ARITH_EN (see vector_alu) switches ADD/MUL to signed lanes.
module vector_cpu
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        instruction,
    input  logic [1:0]        reg_addr,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [VEC_W-1:0]  initialize_value,
    output logic [VEC_W-1:0]  A1_out,
    output logic [VEC_W-1:0]  A2_out,
    output logic [VEC_W-1:0]  A3_out,
    output logic [VEC_W-1:0]  A4_out
);

    logic [VEC_W-1:0]   vreg [4];
    logic [LANE_W-1:0]  mem  [MEM_DEPTH];
    logic [2*VEC_W-1:0] alu_result;
    logic               op_mul;

    assign op_mul = (instruction == OP_MUL);

    vector_alu u_alu (
        .a      (vreg[REG_A1]),
        .b      (vreg[REG_A2]),
        .op_mul (op_mul),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 4; r++) begin
                vreg[r] <= '0;
            end
        end else begin
            case (instruction)
                OP_LOAD: begin
                    for (int i = 0; i < LANES; i++) begin
                        vreg[reg_addr][i*LANE_W +: LANE_W] <= mem[lane_addr(mem_address, i)];
                    end
                end
                OP_ADD, OP_MUL: begin
                    vreg[REG_A3] <= alu_result[VEC_W-1:0];
                    vreg[REG_A4] <= alu_result[2*VEC_W-1:VEC_W];
                end
                OP_INIT: vreg[reg_addr] <= initialize_value;
                default: ;
            endcase
        end
    end

    // Memory survives reset; reset only suppresses a STORE presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && instruction == OP_STORE) begin
            for (int i = 0; i < LANES; i++) begin
                mem[lane_addr(mem_address, i)] <= vreg[reg_addr][i*LANE_W +: LANE_W];
            end
        end
    end

    assign A1_out = vreg[REG_A1];
    assign A2_out = vreg[REG_A2];
    assign A3_out = vreg[REG_A3];
    assign A4_out = vreg[REG_A4];

endmodule

// File: tb/tb_vector_cpu.sv
// Self-checking bench for vector_cpu against a lane/word-array reference model.
module tb_vector_cpu;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   instruction = 3'b101;
    logic [1:0]   reg_addr = 2'b00;
    logic [8:0]   mem_address = 9'd0;
    logic [511:0] initialize_value = '0;
    logic [511:0] A1_out, A2_out, A3_out, A4_out;
    logic [511:0] outs [4];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_reg [4][16];
    logic [31:0] m_mem [512];

    vector_cpu dut (
        .clk              (clk),
        .rst              (rst),
        .instruction      (instruction),
        .reg_addr         (reg_addr),
        .mem_address      (mem_address),
        .initialize_value (initialize_value),
        .A1_out           (A1_out),
        .A2_out           (A2_out),
        .A3_out           (A3_out),
        .A4_out           (A4_out)
    );

    assign outs[0] = A1_out;
    assign outs[1] = A2_out;
    assign outs[2] = A3_out;
    assign outs[3] = A4_out;

    initial forever #5 clk = ~clk;

    function automatic logic [511:0] mdl_vec(input int r);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = m_reg[r][i];
        return v;
    endfunction

    function automatic logic [511:0] rand_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] pattern_vec();
        logic [511:0] v = '0;
        v[0*32 +: 32]  = 32'd1;
        v[2*32 +: 32]  = 32'd8;
        v[5*32 +: 32]  = 32'd9;
        v[6*32 +: 32]  = 32'd1048576;
        v[8*32 +: 32]  = 32'd2;
        v[13*32 +: 32] = 32'd24;
        v[14*32 +: 32] = 32'd1;
        return v;
    endfunction

    function automatic logic [63:0] ref_alu(input bit mul, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
`ifdef CPU_SIGNED_ARITH_EN
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`else
        sa = longint'(a);
        sb = longint'(b);
`endif
        return mul ? 64'(sa * sb) : 64'(sa + sb);
    endfunction

    // Drive one instruction, clock it, and advance the model by the architectural rules.
    task automatic issue(input logic r, input logic [2:0] op, input logic [1:0] ra,
                         input logic [8:0] ad, input logic [511:0] iv);
        logic [63:0] res;
        rst = r;
        instruction = op;
        reg_addr = ra;
        mem_address = ad;
        initialize_value = iv;
        @(posedge clk);
        #1;
        if (r) begin
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 16; i++) m_reg[k][i] = '0;
        end else begin
            case (op)
                3'b000: for (int i = 0; i < 16; i++) m_reg[ra][i] = m_mem[(int'(ad) + i) % 512];
                3'b001: for (int i = 0; i < 16; i++) m_mem[(int'(ad) + i) % 512] = m_reg[ra][i];
                3'b010, 3'b011: begin
                    for (int i = 0; i < 16; i++) begin
                        res = ref_alu(op == 3'b011, m_reg[0][i], m_reg[1][i]);
                        m_reg[2][i] = res[31:0];
                        m_reg[3][i] = res[63:32];
                    end
                end
                3'b100: for (int i = 0; i < 16; i++) m_reg[ra][i] = iv[i*32 +: 32];
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        issue(1'b1, 3'b000, 2'd0, 9'd0, '0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (outs[k] !== 512'd0) begin
                errors++;
                $display("FAIL reset_A%0d got %h want 0", k + 1, outs[k]);
            end
        end
        issue(1'b0, 3'b101, 2'd2, 9'd7, rand_vec());
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (outs[k] !== 512'd0) begin
                errors++;
                $display("FAIL nop_after_reset_A%0d got %h want 0", k + 1, outs[k]);
            end
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 32; k++) begin
            issue(1'b0, 3'b100, 2'd0, 9'd0, rand_vec());
            issue(1'b0, 3'b001, 2'd0, 9'(k * 16), '0);
        end
        issue(1'b0, 3'b000, 2'd1, 9'd37, '0);
        checks++;
        if (A2_out !== mdl_vec(1)) begin
            errors++;
            $display("FAIL fill_load got %h want %h", A2_out, mdl_vec(1));
        end
    endtask

    task automatic test_init_mul();
        logic [511:0] pat = pattern_vec();
        logic [511:0] exp3 = '0;
        logic [511:0] exp4 = '0;
        issue(1'b0, 3'b100, 2'd0, 9'd0, pat);
        issue(1'b0, 3'b100, 2'd1, 9'd0, pat);
        checks++;
        if (A1_out !== pat) begin errors++; $display("FAIL init_A1 got %h want %h", A1_out, pat); end
        checks++;
        if (A2_out !== pat) begin errors++; $display("FAIL init_A2 got %h want %h", A2_out, pat); end
        exp3[0*32 +: 32]  = 32'd1;
        exp3[2*32 +: 32]  = 32'd64;
        exp3[5*32 +: 32]  = 32'd81;
        exp3[8*32 +: 32]  = 32'd4;
        exp3[13*32 +: 32] = 32'd576;
        exp3[14*32 +: 32] = 32'd1;
        exp4[6*32 +: 32]  = 32'h100;
        issue(1'b0, 3'b011, 2'd1, 9'd99, '0);
        checks++;
        if (A3_out !== exp3) begin errors++; $display("FAIL mul_A3 got %h want %h", A3_out, exp3); end
        checks++;
        if (A4_out !== exp4) begin errors++; $display("FAIL mul_A4 got %h want %h", A4_out, exp4); end
        checks++;
        if (A1_out !== pat) begin errors++; $display("FAIL mul_A1_hold got %h want %h", A1_out, pat); end
    endtask

    task automatic test_store_add_load();
        logic [511:0] pat = pattern_vec();
        logic [511:0] a1 = '0;
        a1[127:0] = {32'd4, 32'd3, 32'd2, 32'd1};
        issue(1'b0, 3'b001, 2'd1, 9'd10, '0);
        issue(1'b0, 3'b100, 2'd0, 9'd0, a1);
        issue(1'b0, 3'b010, 2'd3, 9'd200, '0);
        checks++;
        if (A3_out[127:0] !== {32'd4, 32'd11, 32'd2, 32'd2}) begin
            errors++;
            $display("FAIL add_A3_low got %h want %h", A3_out[127:0], {32'd4, 32'd11, 32'd2, 32'd2});
        end
        checks++;
        if (A3_out !== mdl_vec(2)) begin errors++; $display("FAIL add_A3 got %h want %h", A3_out, mdl_vec(2)); end
        checks++;
        if (A4_out !== 512'd0) begin errors++; $display("FAIL add_A4 got %h want 0", A4_out); end
        issue(1'b0, 3'b000, 2'd0, 9'd10, '0);
        checks++;
        if (A1_out !== pat) begin errors++; $display("FAIL load_A1 got %h want %h", A1_out, pat); end
    endtask

    task automatic test_overflow();
        logic [511:0] v1 = '0;
        logic [511:0] v2 = '0;
        logic [31:0] e3, e4;
        v1[31:0] = 32'hFFFF_FFFF;
        v2[31:0] = 32'd1;
        issue(1'b0, 3'b100, 2'd0, 9'd0, v1);
        issue(1'b0, 3'b100, 2'd1, 9'd0, v2);
        issue(1'b0, 3'b010, 2'd0, 9'd0, '0);
`ifdef CPU_SIGNED_ARITH_EN
        e4 = 32'd0;
`else
        e4 = 32'd1;
`endif
        checks++;
        if (A3_out[31:0] !== 32'd0) begin errors++; $display("FAIL ovf_add_A3 got %h want 0", A3_out[31:0]); end
        checks++;
        if (A4_out[31:0] !== e4) begin errors++; $display("FAIL ovf_add_A4 got %h want %h", A4_out[31:0], e4); end
        issue(1'b0, 3'b100, 2'd1, 9'd0, v1);
        issue(1'b0, 3'b011, 2'd0, 9'd0, '0);
`ifdef CPU_SIGNED_ARITH_EN
        e3 = 32'd1; e4 = 32'd0;
`else
        e3 = 32'd1; e4 = 32'hFFFF_FFFE;
`endif
        checks++;
        if (A3_out[31:0] !== e3) begin errors++; $display("FAIL ovf_mul_A3 got %h want %h", A3_out[31:0], e3); end
        checks++;
        if (A4_out[31:0] !== e4) begin errors++; $display("FAIL ovf_mul_A4 got %h want %h", A4_out[31:0], e4); end
    endtask

    task automatic test_wrap();
        logic [511:0] v = rand_vec();
        issue(1'b0, 3'b100, 2'd2, 9'd0, v);
        issue(1'b0, 3'b001, 2'd2, 9'd510, '0);
        issue(1'b0, 3'b000, 2'd3, 9'd510, '0);
        checks++;
        if (A4_out !== v) begin errors++; $display("FAIL wrap_load510 got %h want %h", A4_out, v); end
        issue(1'b0, 3'b000, 2'd0, 9'd0, '0);
        checks++;
        if (A1_out[447:0] !== v[511:64]) begin
            errors++;
            $display("FAIL wrap_load0 got %h want %h", A1_out[447:0], v[511:64]);
        end
        checks++;
        if (A1_out !== mdl_vec(0)) begin errors++; $display("FAIL wrap_load0_full got %h want %h", A1_out, mdl_vec(0)); end
    endtask

    task automatic test_back_to_back();
        logic [511:0] w = rand_vec();
        issue(1'b0, 3'b100, 2'd1, 9'd0, w);
        issue(1'b0, 3'b001, 2'd1, 9'd300, '0);
        issue(1'b0, 3'b000, 2'd0, 9'd300, '0);
        checks++;
        if (A1_out !== w) begin errors++; $display("FAIL b2b_load got %h want %h", A1_out, w); end
        issue(1'b1, 3'b001, 2'd1, 9'd300, '0);
        issue(1'b0, 3'b000, 2'd2, 9'd300, '0);
        checks++;
        if (A3_out !== w) begin errors++; $display("FAIL reset_blocks_store got %h want %h", A3_out, w); end
    endtask

    task automatic test_random();
        logic r;
        for (int n = 0; n < 300; n++) begin
            r = ($urandom_range(0, 24) == 0);
            issue(r, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  9'($urandom_range(0, 511)), rand_vec());
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (outs[k] !== mdl_vec(k)) begin
                    errors++;
                    $display("FAIL rand%0d_A%0d got %h want %h", n, k + 1, outs[k], mdl_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_init_mul();
        test_store_add_load();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
